// File: rtl/dds_pkg.sv
// Shared waveform-mode encodings and the sine table generator used when no INIT_FILE is supplied.
// Pure definitions: no clocked logic.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE = 2'd0,
        MODE_TRI  = 2'd1,
        MODE_SAW  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_e;

    localparam real PI = 3.14159265358979323846;

    // |sin| at the centre of phase step idx out of 2^aw, scaled to a (dw-1)-bit magnitude
    function automatic int sine_mag(input int idx, input int aw, input int dw);
        real s;
        s = $sin(2.0 * PI * (real'(idx) + 0.5) / real'(1 << aw));
        if (s < 0.0) s = -s;
        return int'($floor(real'((1 << (dw - 1)) - 1) * s + 0.5));
    endfunction

    function automatic int sine_code(input int idx, input int aw, input int dw);
        if (idx < (1 << (aw - 1)))
            return (1 << (dw - 1)) + sine_mag(idx, aw, dw);
        return (1 << (dw - 1)) - 1 - sine_mag(idx, aw, dw);
    endfunction

endpackage

// File: rtl/dds_qw_rom.sv
// Sine storage with registered read; quarter-wave magnitudes when DDS_WAVE_ROM_QUARTER_WAVE_EN, else full cycle.
// Latency 1 cycle; reads every cycle, no backpressure. Contents are never reset.
module dds_qw_rom
    import dds_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 8,
    parameter string INIT_FILE  = "sin_qw.txt"
) (
    input  logic                  clk,
`ifdef DDS_WAVE_ROM_QUARTER_WAVE_EN
    input  logic [ADDR_WIDTH-3:0] addr,
    output logic [DATA_WIDTH-2:0] rdata
`else
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] rdata
`endif
);

`ifdef DDS_WAVE_ROM_QUARTER_WAVE_EN
    localparam int ROM_AW = ADDR_WIDTH - 2;
    localparam int ROM_DW = DATA_WIDTH - 1;
`else
    localparam int ROM_AW = ADDR_WIDTH;
    localparam int ROM_DW = DATA_WIDTH;
`endif
    localparam int ROM_DEPTH = 1 << ROM_AW;

    logic [ROM_DW-1:0] mem [ROM_DEPTH];

    // Table contents are built arithmetically at elaboration.
    initial begin
        for (int k = 0; k < ROM_DEPTH; k++) begin
`ifdef DDS_WAVE_ROM_QUARTER_WAVE_EN
            mem[k] = ROM_DW'(sine_mag(k, ADDR_WIDTH, DATA_WIDTH));
`else
            mem[k] = ROM_DW'(sine_code(k, ADDR_WIDTH, DATA_WIDTH));
`endif
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dds_wave_rom.sv
// DDS waveform generator (sine/triangle/sawtooth/square); DDS_WAVE_ROM_QUARTER_WAVE_EN selects quarter-wave sine storage.
// Latency 2 cycles from en; one sample per strobe, no backpressure; q holds between samples.
module dds_wave_rom
    import dds_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 8,
    parameter string INIT_FILE  = "sin_qw.txt"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] phase,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid
);

    localparam int MSB = ADDR_WIDTH - 1;

`ifdef DDS_WAVE_ROM_QUARTER_WAVE_EN
    logic [ADDR_WIDTH-3:0] rom_addr;
    logic [DATA_WIDTH-2:0] rom_data;

    // Quadrants 1 and 3 walk the quarter table backwards.
    assign rom_addr = phase[MSB-1] ? ~phase[ADDR_WIDTH-3:0] : phase[ADDR_WIDTH-3:0];
`else
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    assign rom_addr = phase;
`endif

    dds_qw_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_rom (
        .clk   (clk),
        .addr  (rom_addr),
        .rdata (rom_data)
    );

    logic                  s1_vld;
    mode_e                 s1_mode;
    logic [ADDR_WIDTH-1:0] s1_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_mode  <= MODE_SINE;
            s1_phase <= '0;
        end else begin
            s1_vld <= en;
            if (en) begin
                s1_mode  <= mode_e'(mode);
                s1_phase <= phase;
            end
        end
    end

    logic [DATA_WIDTH-1:0] sine_q;
    logic [DATA_WIDTH-1:0] wave;
    logic [ADDR_WIDTH-1:0] tri_t;

`ifdef DDS_WAVE_ROM_QUARTER_WAVE_EN
    // Negative half mirrors below mid-scale: 2^(N-1)-1-A is just {0, ~A}.
    assign sine_q = s1_phase[MSB] ? {1'b0, ~rom_data} : {1'b1, rom_data};
`else
    assign sine_q = rom_data;
`endif

    always_comb begin
        tri_t = {s1_phase[MSB-1:0], 1'b0};
        if (s1_phase[MSB]) tri_t = ~tri_t;
        wave = '0;
        unique case (s1_mode)
            MODE_SINE: wave = sine_q;
            MODE_TRI:  wave = DATA_WIDTH'({tri_t, {DATA_WIDTH{1'b0}}} >> ADDR_WIDTH);
            MODE_SAW:  wave = DATA_WIDTH'({s1_phase, {DATA_WIDTH{1'b0}}} >> ADDR_WIDTH);
            MODE_SQR:  wave = {DATA_WIDTH{~s1_phase[MSB]}};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= s1_vld;
            if (s1_vld) q <= wave;
        end
    end

endmodule

// File: tb/tb_dds_wave_rom.sv
// Directed bench for dds_wave_rom (8-bit sample, 8-bit phase) with a scoreboard of expected samples.
module tb_dds_wave_rom;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] phase;
    logic [1:0] mode;
    logic [7:0] q;
    logic       q_valid;

    always #5 clk = ~clk;

    dds_wave_rom #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .INIT_FILE  ("")
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .phase   (phase),
        .mode    (mode),
        .q       (q),
        .q_valid (q_valid)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] phase;
        logic [7:0] exp;
    } sb_t;

    sb_t        sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       pend     = 1'b0;
    logic [7:0] last_q   = 8'h00;
    logic [7:0] sin_obs [256];

    function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] p);
        real        s;
        int         mag;
        logic [7:0] t;
        case (m)
            2'd0: begin
                s   = $sin(2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / 256.0);
                mag = $rtoi($floor((s < 0.0 ? -s : s) * 127.0 + 0.5));
                return (s >= 0.0) ? 8'(128 + mag) : 8'(127 - mag);
            end
            2'd1: begin
                t = {p[6:0], 1'b0};
                return p[7] ? ~t : t;
            end
            2'd2: return p;
            default: return p[7] ? 8'h00 : 8'hFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then check whatever the output stage now carries.
    task automatic step(input logic e, input logic [7:0] p, input logic [1:0] m);
        sb_t it;
        en    = e;
        phase = p;
        mode  = m;
        if (e) sb.push_back('{m, p, model(m, p)});
        @(posedge clk);
        #1;
        check("q_valid", 16'(q_valid), 16'(pend));
        if (pend) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 16'(sb.size()), 16'd1);
            end else begin
                it = sb.pop_front();
                check($sformatf("q_mode%0d_ph%02h", it.mode, it.phase), 16'(q), 16'(it.exp));
                last_q = it.exp;
                if (it.mode == 2'd0) sin_obs[it.phase] = q;
            end
        end else begin
            check("q_hold", 16'(q), 16'(last_q));
        end
        pend = e;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        phase = 8'h00;
        mode  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", 16'(q), 16'h0000);
        check("reset_q_valid", 16'(q_valid), 16'h0000);
        rst = 1'b0;
        step(1'b0, 8'h00, 2'd0);

        // square then sawtooth then triangle, mode changing between back-to-back strobes
        step(1'b1, 8'h10, 2'd3);
        step(1'b1, 8'h80, 2'd3);
        step(1'b1, 8'h5A, 2'd2);
        step(1'b1, 8'h40, 2'd1);
        step(1'b1, 8'hC0, 2'd1);
        step(1'b0, 8'h00, 2'd0);
        step(1'b0, 8'h00, 2'd0);

        // gapped strobes: q must hold across the idle cycles
        step(1'b1, 8'h33, 2'd2);
        step(1'b0, 8'hAA, 2'd1);
        step(1'b0, 8'h55, 2'd3);
        step(1'b1, 8'h44, 2'd2);
        step(1'b0, 8'h00, 2'd0);
        step(1'b0, 8'h00, 2'd0);

        // phase wrap for triangle and sawtooth
        step(1'b1, 8'hFE, 2'd1);
        step(1'b1, 8'hFF, 2'd1);
        step(1'b1, 8'h00, 2'd1);
        step(1'b1, 8'h01, 2'd1);
        step(1'b1, 8'hFF, 2'd2);
        step(1'b1, 8'h00, 2'd2);
        step(1'b0, 8'h00, 2'd0);
        step(1'b0, 8'h00, 2'd0);

        // full sine sweep
        for (int p = 0; p < 256; p++) step(1'b1, 8'(p), 2'd0);
        step(1'b0, 8'h00, 2'd0);
        step(1'b0, 8'h00, 2'd0);
        for (int p = 0; p < 128; p++) begin
            check($sformatf("sin_mirror_%02h", p), 16'(sin_obs[p]), 16'(sin_obs[8'h7F - p]));
            check($sformatf("sin_antisym_%02h", p),
                  16'(sin_obs[p]) + 16'(sin_obs[p ^ 8'h80]), 16'h00FF);
        end

        // reset with samples in flight
        step(1'b1, 8'h20, 2'd2);
        step(1'b1, 8'h21, 2'd2);
        en    = 1'b1;
        phase = 8'h22;
        mode  = 2'd2;
        #2 rst = 1'b1;
        #1;
        check("midrst_q", 16'(q), 16'h0000);
        check("midrst_q_valid", 16'(q_valid), 16'h0000);
        @(posedge clk);
        #2;
        rst = 1'b0;
        en  = 1'b0;
        sb.delete();
        pend   = 1'b0;
        last_q = 8'h00;
        step(1'b0, 8'h00, 2'd0);
        step(1'b0, 8'h00, 2'd0);
        step(1'b0, 8'h00, 2'd0);
        step(1'b1, 8'h77, 2'd2);
        step(1'b0, 8'h00, 2'd0);
        step(1'b0, 8'h00, 2'd0);
        check("scoreboard_drained", 16'(sb.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
